// File: rtl/debounce_sched_pkg.sv
// -----------------------------------------------------------------------------
// debounce_sched_pkg
// Shared types and constants for the shared-timer switch debouncer.
//   state_t                 : scheduler state (IDLE = timer free, COUNT = held)
//   DEFAULT_DEBOUNCE_CYCLES : default stable-cycle requirement
//   MIN_*                   : lower bounds on the configurable parameters
//   params_ok()             : elaboration-time parameter sanity check
// -----------------------------------------------------------------------------
package debounce_sched_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 120;

  localparam int MIN_NUM_CH          = 2;
  localparam int MIN_DEBOUNCE_CYCLES = 2;
  localparam int MIN_SYNC_STAGES     = 2;

  // True when every parameter meets its minimum.
  function automatic bit params_ok(input int num_ch, input int db_cycles,
                                   input int sync_stages);
    return (num_ch >= MIN_NUM_CH) &&
           (db_cycles >= MIN_DEBOUNCE_CYCLES) &&
           (sync_stages >= MIN_SYNC_STAGES);
  endfunction

endpackage

// File: rtl/debounce_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. Searches last_grant+1,
// last_grant+2, ... (modulo NUM_CH) and returns the first requesting channel.
// Ports:
//   i_req          NUM_CH  request vector (one bit per channel)
//   i_last_grant   CH_W    channel granted most recently
//   o_grant_valid  1       at least one request present
//   o_grant_idx    CH_W    selected channel (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter
  import debounce_sched_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [CH_W-1:0]   i_last_grant,
  output logic              o_grant_valid,
  output logic [CH_W-1:0]   o_grant_idx
);

  logic [CH_W-1:0] w_cand;
  logic            w_hit;

  // Walk the rotation farthest-first so the nearest requester overwrites.
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    w_cand        = '0;
    w_hit         = 1'b0;
    for (int k = NUM_CH; k >= 1; k--) begin
      w_cand        = CH_W'((int'(i_last_grant) + k) % NUM_CH);
      w_hit         = i_req[w_cand];
      o_grant_valid = o_grant_valid | w_hit;
      o_grant_idx   = w_hit ? w_cand : o_grant_idx;
    end
  end

endmodule

// File: rtl/debounce_scheduler.sv
// -----------------------------------------------------------------------------
// debounce_scheduler
// One debounce timer shared by NUM_CH switch inputs. Each input is
// synchronized and compared with its committed level; differing channels
// request the timer, a round-robin arbiter grants one, and the grant commits
// only if the input stays changed for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk_i        1       system clock (rising edge)
//   rst_i        1       asynchronous active-high reset
//   sw_i         NUM_CH  raw asynchronous switch inputs
//   db_level_o   NUM_CH  debounced stable level per channel
//   db_tick_o    NUM_CH  one-cycle pulse on a committed 0->1 change
//   busy_o       1       timer allocated (state COUNT)
//   active_ch_o  CH_W    channel owning the timer; valid while busy_o=1
// -----------------------------------------------------------------------------
module debounce_scheduler
  import debounce_sched_pkg::*;
#(
  parameter  int NUM_CH          = 4,
  parameter  int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter  int SYNC_STAGES     = 2,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES),
  localparam int CH_W            = $clog2(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] sw_i,
  output logic [NUM_CH-1:0] db_level_o,
  output logic [NUM_CH-1:0] db_tick_o,
  output logic              busy_o,
  output logic [CH_W-1:0]   active_ch_o
);

  if (!params_ok(NUM_CH, DEBOUNCE_CYCLES, SYNC_STAGES)) begin : g_param_err
    $error("debounce_scheduler: NUM_CH, DEBOUNCE_CYCLES and SYNC_STAGES must each be >= 2");
  end

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CH_W-1:0]  LAST_RESET = CH_W'(NUM_CH - 1);

  // Synchronizer chain: row 0 samples sw_i, row SYNC_STAGES-1 is the output.
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] r_sync;
  logic [NUM_CH-1:0]                  w_sync;
  logic [NUM_CH-1:0]                  w_pending;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CH_W-1:0]   r_ch;
  logic [CH_W-1:0]   w_ch_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CH_W-1:0]   r_last_grant;
  logic [CH_W-1:0]   w_last_grant_nxt;
  logic [NUM_CH-1:0] r_level;
  logic [NUM_CH-1:0] w_level_nxt;
  logic [NUM_CH-1:0] r_tick;
  logic [NUM_CH-1:0] w_tick_nxt;
  logic              r_busy;

  logic              w_grant_valid;
  logic [CH_W-1:0]   w_grant_idx;

  // Synchronizer flops for every raw switch input.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sw_i};
    end
  end

  assign w_sync    = r_sync[SYNC_STAGES-1];
  assign w_pending = w_sync ^ r_level;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .i_req         (w_pending),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  // Next-state logic: grant in IDLE; abort, commit or count in COUNT.
  always_comb begin
    w_state_nxt      = r_state;
    w_ch_nxt         = r_ch;
    w_cnt_nxt        = r_cnt;
    w_last_grant_nxt = r_last_grant;
    w_level_nxt      = r_level;
    w_tick_nxt       = '0;
    case (r_state)
      IDLE: begin
        if (w_grant_valid) begin
          w_state_nxt = COUNT;
          w_ch_nxt    = w_grant_idx;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      COUNT: begin
        // Abort takes priority, so a commit always changes the level.
        if (w_sync[r_ch] == r_level[r_ch]) begin
          w_state_nxt      = IDLE;
          w_last_grant_nxt = r_ch;
          w_cnt_nxt        = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt       = IDLE;
          w_last_grant_nxt  = r_ch;
          w_cnt_nxt         = '0;
          w_level_nxt[r_ch] = w_sync[r_ch];
          w_tick_nxt[r_ch]  = w_sync[r_ch];
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Scheduler state and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_ch         <= '0;
      r_cnt        <= '0;
      r_last_grant <= LAST_RESET;
      r_level      <= '0;
      r_tick       <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ch         <= w_ch_nxt;
      r_cnt        <= w_cnt_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_level      <= w_level_nxt;
      r_tick       <= w_tick_nxt;
      r_busy       <= (w_state_nxt == COUNT);
    end
  end

  assign db_level_o  = r_level;
  assign db_tick_o   = r_tick;
  assign busy_o      = r_busy;
  assign active_ch_o = r_ch;

endmodule
